// File: rtl/spwm_pkg.sv
// Shared types, sizes and constants for the SPWM DDS sample source.
// SPWM_DDS_DITHER_EN selects LFSR phase dither in spwm_dds_source.
package spwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        READY
    } state_e;

    localparam int DEF_PHASE_W = 32;
    localparam int DEF_LUT_AW  = 8;
    localparam int DEF_OUT_W   = 16;

    localparam logic [15:0] Q15_ONE   = 16'h8000;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic int unsigned mid_of(input int w);
        return 32'd1 << (w - 1);
    endfunction

    // Rounded quarter-wave entry, sampled at the bin centre.
    function automatic int sine_entry(input int k, input int aw, input int dw);
        real x;
        real term;
        real acc;
        x    = 1.5707963267948966 * ($itor(k) + 0.5) / $itor(32'sd1 << aw);
        term = x;
        acc  = x;
        for (int n = 1; n < 10; n++) begin
            term = -term * x * x / $itor((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return $rtoi($itor((32'sd1 << dw) - 1) * acc + 0.5);
    endfunction

endpackage

// File: rtl/sine_qrom.sv
// Quarter-wave sine ROM with registered read port.
// Contents are computed at elaboration from spwm_pkg::sine_entry.
module sine_qrom
    import spwm_pkg::*;
#(
    parameter int AW = DEF_LUT_AW,
    parameter int DW = DEF_OUT_W - 1
) (
    input  logic          clk,
    input  logic          rd_en_i,
    input  logic [AW-1:0] addr_i,
    output logic [DW-1:0] data_o
);

    logic [DW-1:0] tbl [2**AW];
    logic [DW-1:0] data_q;

    for (genvar k = 0; k < 2**AW; k++) begin : g_rom
        localparam logic [DW-1:0] V = DW'(sine_entry(k, AW, DW));
        assign tbl[k] = V;
    end

    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            data_q <= tbl[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/spwm_dds_source.sv
// DDS sine sample source feeding the SPWM modulator, one sample per grant.
// Define SPWM_DDS_DITHER_EN to add LFSR dither below the ROM address bits.
module spwm_dds_source
    import spwm_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int LUT_AW  = DEF_LUT_AW,
    parameter int OUT_W   = DEF_OUT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] ftw_in,
    input  logic               ftw_load,
    input  logic [15:0]        amp,
    input  logic               grant,
    input  logic               clear_err,
    output logic [OUT_W-1:0]   sample,
    output logic               sample_upd,
    output logic               underrun
);

    localparam logic [OUT_W-1:0] MID = OUT_W'(mid_of(OUT_W));
    localparam int PW = OUT_W + 17;
    localparam int FW = PHASE_W - 2 - LUT_AW;

    state_e               state_q, state_d;
    logic [1:0]           cnt_q;
    logic                 f1, f2, f3, accept;
    logic [PHASE_W-1:0]   phase_q, ftw_q, ph_f1;
    logic [LUT_AW-1:0]    addr_q;
    logic                 neg1_q, neg2_q;
    logic [OUT_W-2:0]     rom_data;
    logic [OUT_W-1:0]     nxt_q, nxt_d, sample_q;
    logic                 upd_q, unr_q;
    logic [15:0]          amp_c;
    logic signed [PW-1:0] s_x, scaled;
    logic                 unused_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == FILL && state_d == FILL) ? cnt_q + 2'd1 : 2'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = FILL;
            FILL:    if (f3) state_d = READY;
            READY:   if (accept) state_d = FILL;
            default: state_d = IDLE;
        endcase
        if (!en) state_d = IDLE;
    end

    always_comb begin
        f1     = 1'b0;
        f2     = 1'b0;
        f3     = 1'b0;
        accept = 1'b0;
        unique case (state_q)
            FILL: begin
                f1 = en && cnt_q == 2'd0;
                f2 = en && cnt_q == 2'd1;
                f3 = en && cnt_q == 2'd2;
            end
            READY:   accept = en && grant;
            default: ;
        endcase
    end

    // The advance uses the tuning word held before any same-cycle load.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            ftw_q   <= '0;
        end else begin
            if (accept) phase_q <= phase_q + ftw_q;
            if (ftw_load) ftw_q <= ftw_in;
        end
    end

`ifdef SPWM_DDS_DITHER_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (f1) begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign ph_f1 = {phase_q[PHASE_W-1 -: LUT_AW + 2],
                    phase_q[FW-1:0] + FW'(lfsr_q)};
`else
    assign ph_f1 = phase_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            neg1_q <= 1'b0;
            neg2_q <= 1'b0;
            nxt_q  <= MID;
        end else begin
            if (f1) begin
                addr_q <= ph_f1[PHASE_W-2] ? ~ph_f1[PHASE_W-3 -: LUT_AW]
                                           : ph_f1[PHASE_W-3 -: LUT_AW];
                neg1_q <= ph_f1[PHASE_W-1];
            end
            if (f2) neg2_q <= neg1_q;
            if (f3) nxt_q <= nxt_d;
        end
    end

    sine_qrom #(
        .AW (LUT_AW),
        .DW (OUT_W - 1)
    ) u_rom (
        .clk     (clk),
        .rd_en_i (f2),
        .addr_i  (addr_q),
        .data_o  (rom_data)
    );

    assign amp_c = (amp > Q15_ONE) ? Q15_ONE : amp;

    always_comb begin
        s_x = PW'($signed({1'b0, rom_data}));
        if (neg2_q) s_x = -s_x;
        scaled = (s_x * PW'($signed({1'b0, amp_c}))) >>> 15;
        nxt_d  = scaled[OUT_W-1:0] + MID;
    end

    // A set event outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= MID;
            upd_q    <= 1'b0;
            unr_q    <= 1'b0;
        end else begin
            upd_q <= accept;
            if (!en) begin
                sample_q <= MID;
            end else if (accept) begin
                sample_q <= nxt_q;
            end
            if (en && grant && !accept) begin
                unr_q <= 1'b1;
            end else if (clear_err) begin
                unr_q <= 1'b0;
            end
        end
    end

    assign unused_bits = ^{ph_f1[FW-1:0], scaled[PW-1:OUT_W]};

    assign sample     = sample_q;
    assign sample_upd = upd_q;
    assign underrun   = unr_q;

endmodule

// File: tb/tb_spwm_dds_source.sv
// Bench for spwm_dds_source: test-plan sequences plus a randomized run,
// scored against a sine/scale reference model through an expectation queue.
`timescale 1ns/1ps
module tb_spwm_dds_source;

    logic        clk = 1'b0;
    logic        rst, en, ftw_load, grant, clear_err;
    logic [31:0] ftw_in;
    logic [15:0] amp;
    logic [15:0] sample;
    logic        sample_upd, underrun;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    typedef struct {
        int     val;
        longint at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    logic [31:0] m_phase, m_ftw, pf_phase;
    logic [15:0] pf_amp;
    longint      ready_at;
    bit          m_unr;
    int          last_val;

    spwm_dds_source dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ftw_in     (ftw_in),
        .ftw_load   (ftw_load),
        .amp        (amp),
        .grant      (grant),
        .clear_err  (clear_err),
        .sample     (sample),
        .sample_upd (sample_upd),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Sine of the centre of the 1024-bin phase cell, rounded, then Q1.15 scaled.
    function automatic int ref_sample(input logic [31:0] ph, input logic [15:0] a);
        int     idx;
        real    v;
        int     s;
        int     ac;
        longint p;
        idx = int'(ph >> 22);
        v   = $sin(6.283185307179586 * ($itor(idx) + 0.5) / 1024.0);
        s   = $rtoi(32767.0 * ((v < 0.0) ? -v : v) + 0.5);
        if (v < 0.0) s = -s;
        ac = (a > 16'h8000) ? 32768 : int'(a);
        p  = longint'(s) * longint'(ac);
        if (p >= 0) p = p / 32768;
        else p = -((-p + 32767) / 32768);
        return 32768 + int'(p);
    endfunction

    always @(negedge clk) begin
        if (!rst && sample_upd) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_upd: got sample %0d at cycle %0d, expected no update",
                         sample, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sample", longint'(sample), longint'(mon_e.val));
                chk("upd_cycle", cyc, mon_e.at);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input bit g, input bit ld, input logic [31:0] f, input bit clr);
        bit   acc;
        exp_t e;
        grant     = g;
        ftw_load  = ld;
        ftw_in    = f;
        clear_err = clr;
        acc = g && en && (cyc >= ready_at);
        if (acc) begin
            e.val = ref_sample(pf_phase, pf_amp);
            e.at  = cyc + 1;
            exp_q.push_back(e);
            last_val = e.val;
            m_phase  = m_phase + m_ftw;
            pf_phase = m_phase;
            pf_amp   = amp;
            ready_at = cyc + 4;
        end
        if (ld) m_ftw = f;
        if (g && en && !acc) m_unr = 1'b1;
        else if (clr) m_unr = 1'b0;
        tick();
        grant     = 1'b0;
        ftw_load  = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) slot(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic set_en(input bit v);
        if (v && !en) begin
            ready_at = cyc + 4;
            pf_phase = m_phase;
            pf_amp   = amp;
        end
        en = v;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) tick();
        rst     = 1'b0;
        m_phase = '0;
        m_ftw   = '0;
        m_unr   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("queue_drained", longint'(exp_q.size()), 0);
    endtask

    int qexp[5] = '{32869, 65535, 32667, 1, 32869};

    initial begin
        grant = 0; ftw_load = 0; ftw_in = 0; clear_err = 0;
        amp = 16'h8000; ready_at = 0; last_val = 32768;
        pf_phase = 0; pf_amp = 16'h8000;
        do_reset();
        @(negedge clk);
        chk("reset_sample", longint'(sample), 32768);
        chk("reset_upd", longint'(sample_upd), 0);
        chk("reset_underrun", longint'(underrun), 0);

        slot(1'b1, 1'b1, 32'h4000_0000, 1'b0);
        @(negedge clk);
        chk("grant_en0_no_underrun", longint'(underrun), 0);

        set_en(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fill_sample_mid", longint'(sample), 32768);
            chk("fill_underrun", longint'(underrun), 0);
            idle(1);
        end

        for (int i = 0; i < 5; i++) begin
            slot(1'b1, 1'b0, 32'd0, 1'b0);
            @(negedge clk);
            chk("qturn_sample", longint'(sample), longint'(qexp[i]));
            chk("qturn_underrun", longint'(underrun), 0);
            if (i < 4) begin
                idle(1);
                @(negedge clk);
                chk("qturn_upd_pulse", longint'(sample_upd), 0);
                idle(6);
            end
        end

        amp = 16'h4000;
        set_en(1'b0);
        @(negedge clk);
        chk("en_drop_sample", longint'(sample), 32768);
        chk("en_drop_upd", longint'(sample_upd), 0);
        idle(2);
        set_en(1'b1);
        idle(3);
        amp = 16'hFFFF;
        slot(1'b1, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        chk("amp_half_resume", longint'(sample), 49151);
        idle(7);
        slot(1'b1, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        chk("amp_clamp", longint'(sample), 32667);

        idle(3);
        slot(1'b1, 1'b1, 32'h8000_0000, 1'b0);
        idle(3);
        slot(1'b1, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        chk("ftw_old_used", longint'(sample), 32869);
        idle(3);
        slot(1'b1, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        chk("ftw_new_used", longint'(sample), 32667);

        idle(3);
        slot(1'b1, 1'b0, 32'd0, 1'b0);
        idle(1);
        slot(1'b1, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        chk("underrun_set", longint'(underrun), 1);
        chk("underrun_sample_held", longint'(sample), longint'(last_val));
        idle(4);
        @(negedge clk);
        chk("underrun_sticky", longint'(underrun), 1);
        slot(1'b0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        chk("underrun_cleared", longint'(underrun), 0);
        slot(1'b1, 1'b0, 32'd0, 1'b0);
        idle(2);
        slot(1'b1, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        chk("underrun_clr_coincide", longint'(underrun), 1);
        slot(1'b0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        chk("underrun_cleared2", longint'(underrun), 0);

        for (int i = 0; i < 300; i++) begin
            bit          g, ld, clr;
            logic [31:0] f;
            g   = ($urandom % 3) == 0;
            ld  = ($urandom % 16) == 0;
            clr = ($urandom % 8) == 0;
            f   = $urandom;
            if (g && cyc >= ready_at && ($urandom % 2) == 1) amp = 16'($urandom);
            slot(g, ld, f, clr);
            @(negedge clk);
            chk("rand_underrun", longint'(underrun), longint'(m_unr));
        end
        drain();

        do_reset();
        @(negedge clk);
        chk("reset2_sample", longint'(sample), 32768);
        chk("reset2_underrun", longint'(underrun), 0);
        amp = 16'h8000;
        set_en(1'b1);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            slot(1'b1, 1'b0, 32'd0, 1'b0);
            @(negedge clk);
            chk("ftw0_steady", longint'(sample), 32869);
            idle(3);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spwm_dds_source.md
# spwm_dds_source

- Direct-digital-synthesis sample source sitting directly upstream of the SPWM modulator, in the 480 MHz PLL clock domain.
- Replaces the constant modulator input with a sine sample stream. A new sample is delivered whenever the modulator asserts its grant, so the modulator reads one value per PWM frame.
- A phase accumulator addresses a quarter-wave sine ROM, and the result is amplitude-scaled.
- A one-entry prefetch register lets each grant be serviced in one cycle.

## Interface
- PHASE_W, 32, phase accumulator / tuning word width
- LUT_AW, 8, quarter-wave ROM address width (256 entries)
- OUT_W, 16, sample width, unsigned offset binary, midscale MID = 2^(OUT_W-1)
- clk  in  1  single clock (480 MHz PLL output)
- rst  in  1  reset: synchronous, active-high
- en  in  1  run enable
- ftw_in  in  PHASE_W  frequency tuning word
- ftw_load  in  1  one-cycle strobe; captures ftw_in
- amp  in  16  amplitude, unsigned Q1.15; values above 0x8000 are clamped to 0x8000
- grant  in  1  one-cycle sample request from the modulator (PWM_grant)
- clear_err  in  1  clears underrun
- sample  out  OUT_W  modulator input value (x0)
- sample_upd  out  1  one-cycle pulse when sample changes due to a grant
- underrun  out  1  sticky flag: a grant arrived with no prefetched sample

## Operation

**FSM states**
- IDLE → FILL when en=1.
- FILL → READY when pipeline stage F3 completes.
- READY → FILL on an accepted grant.
- Any state → IDLE when en=0.

**Pipeline** (starts on entry to FILL)
- F1: register the ROM address from the phase.
  - Quadrant q = phase[PHASE_W-1:PHASE_W-2].
  - a = phase[PHASE_W-3 -: LUT_AW].
  - Address is a for q=0 and q=2; ~a for q=1 and q=3.
- F2: registered ROM read. Entry k = round((MID-1)·sin(π/2·(k+0.5)/2^LUT_AW)).
- F3: s = ROM value, negated when q ≥ 2. next_q = MID + ((s·amp_c) >>> 15), in signed arithmetic with a (OUT_W+17)-bit intermediate. No saturation is needed.

**Accepted grant** (state READY)
- sample ← next_q.
- sample_upd pulses.
- phase ← phase + ftw (modulo 2^PHASE_W).
- State → FILL.

**Boundary conditions**
- Grant in IDLE or FILL: ignored. underrun ← 1 while en=1. sample and phase are unchanged.
- underrun stays set until clear_err. If clear_err and an underrun event occur in the same cycle, underrun stays 1.
- ftw_load and an accepted grant in the same cycle: the phase advance uses the old ftw. The new ftw applies from the next advance, keeping phase continuous.
- en deassert, including mid-FILL:
  - Next cycle: state IDLE, sample = MID, sample_upd = 0.
  - phase and ftw are held.
  - Re-enable refills from the held phase.
- amp is sampled at F3 of each fill.

## Timing
- Reset values: sample = MID, sample_upd = 0, underrun = 0, phase = 0, ftw = 0, state IDLE.
- en high sampled in cycle e: state is READY in cycle e+4.
- Grant accepted in cycle t:
  - sample and sample_upd are visible at t+1.
  - next READY is at t+4.
  - Grants at t+1..t+3 are underruns.
  - Minimum grant spacing is 4 cycles.
- Each prefetched sample corresponds to the phase before the advance. The first grant after enable outputs the sample for phase 0.

## Configuration
- Macro SPWM_DDS_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1, stepping once per F1) is added to the phase bits below the ROM address.
  - The addition is truncated to that field, so it never carries into the address bits.
  - This spreads truncation spurs.
- Undefined: plain phase truncation, no LFSR logic.

## Structure
- Shared package spwm_pkg holds:
  - state enum {IDLE, FILL, READY}
  - default PHASE_W, LUT_AW, OUT_W
  - MID function
  - Q1.15 unity constant 0x8000
  - LFSR taps and seed
- One sub-module, sine_qrom: quarter-wave ROM, 2^LUT_AW × (OUT_W-1) bits, registered output, contents generated at elaboration.

## Test plan
- Reset, then en=1: sample=0x8000, underrun=0 throughout; READY reached 4 cycles after en.
- Quarter-turn sequence:
  - Stimulus: ftw=0x4000_0000, amp=0x8000, grants every 8 cycles.
  - Required samples: 32869, 65535, 32667, 1, 32869.
  - Required: one sample_upd per grant, each at grant+1.
- Underrun:
  - Stimulus: grants 2 cycles apart.
  - Required: second grant ignored, sample unchanged, underrun=1 until clear_err.
  - Also check clear_err coincident with a new underrun: underrun stays 1.
- Same-cycle ftw_load and grant:
  - Stimulus: ftw 0x4000_0000 loaded, then ftw_load with ftw_in=0x8000_0000 in the same cycle as a grant.
  - Required: phase advances by 0x4000_0000, then by 0x8000_0000.
- en dropped mid-FILL: sample=0x8000 next cycle; re-enable resumes from the held phase.
- Amplitude and dither:
  - amp=0x4000 at phase 0x4000_0000 gives sample 49151.
  - amp=0xFFFF behaves exactly as amp=0x8000.
  - With SPWM_DDS_DITHER_EN and ftw=0: sample stays 32869.
